// File: rtl/octet_tile_feeder_if.sv
// rtl/octet_tile_feeder_if.sv - operand stream, octet control and result stream bundle
interface octet_tile_feeder_if #(
  parameter int A_DATA_WIDTH = 128,
  parameter int B_DATA_WIDTH = 128,
  parameter int C_DATA_WIDTH = 128,
  parameter int IDX_WIDTH    = 32
) ();
  // operand stream
  logic                    in_valid;
  logic                    in_ready;
  logic [A_DATA_WIDTH-1:0] in_a;
  logic [B_DATA_WIDTH-1:0] in_b;
  logic [IDX_WIDTH-1:0]    in_idx;
  logic [C_DATA_WIDTH-1:0] in_c;
  // octet side
  logic                    oct_idle;
  logic                    oct_fetch;
  logic                    oct_write_back;
  logic [C_DATA_WIDTH-1:0] oct_result;
  logic                    oct_start;
  logic                    oct_fetch_done;
  logic [A_DATA_WIDTH-1:0] oct_a;
  logic [B_DATA_WIDTH-1:0] oct_b;
  logic [IDX_WIDTH-1:0]    oct_idx;
  logic [C_DATA_WIDTH-1:0] oct_c;
  // result stream and status
  logic                    out_valid;
  logic                    out_ready;
  logic [C_DATA_WIDTH-1:0] out_data;
  logic [15:0]             tiles_done;
  logic                    overflow;

  // environment side: drives operands, octet status and the consumer
  modport master (
    output in_valid, in_a, in_b, in_idx, in_c,
    output oct_idle, oct_fetch, oct_write_back, oct_result,
    output out_ready,
    input  in_ready, oct_start, oct_fetch_done, oct_a, oct_b, oct_idx, oct_c,
    input  out_valid, out_data, tiles_done, overflow
  );

  // feeder side
  modport slave (
    input  in_valid, in_a, in_b, in_idx, in_c,
    input  oct_idle, oct_fetch, oct_write_back, oct_result,
    input  out_ready,
    output in_ready, oct_start, oct_fetch_done, oct_a, oct_b, oct_idx, oct_c,
    output out_valid, out_data, tiles_done, overflow
  );
endinterface

// File: rtl/octet_tile_feeder.sv
// rtl/octet_tile_feeder.sv - tile buffer, octet sequencer and result FIFO for one octet
module octet_tile_feeder #(
  parameter int A_DATA_WIDTH   = 128,
  parameter int B_DATA_WIDTH   = 128,
  parameter int C_DATA_WIDTH   = 128,
  parameter int IDX_WIDTH      = 32,
  parameter int FETCH_BEATS    = 8,
  parameter int BEAT_CNT_WIDTH = 4,
  parameter int RES_DEPTH      = 16,
  parameter int RES_ADDR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  octet_tile_feeder_if.slave bus
);

  localparam int BUF_AW = $clog2(FETCH_BEATS);
  localparam int CNT_W  = RES_ADDR_WIDTH + 1;

  localparam logic [BEAT_CNT_WIDTH-1:0] LAST_BEAT   = BEAT_CNT_WIDTH'(FETCH_BEATS - 1);
  localparam logic [BEAT_CNT_WIDTH-1:0] ALL_BEATS   = BEAT_CNT_WIDTH'(FETCH_BEATS);
  localparam logic [BEAT_CNT_WIDTH-1:0] BEAT_ONE    = BEAT_CNT_WIDTH'(1);
  localparam logic [CNT_W-1:0]          RES_FULL    = CNT_W'(RES_DEPTH);
  localparam logic [CNT_W-1:0]          SPACE_LIMIT = CNT_W'(RES_DEPTH - FETCH_BEATS);
  localparam logic [CNT_W-1:0]          CNT_ONE     = CNT_W'(1);
  localparam logic [RES_ADDR_WIDTH-1:0] PTR_ONE     = RES_ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    FETCH = 2'd2,
    RUN   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [BEAT_CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic [BEAT_CNT_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
  logic                      fetch_done_q, fetch_done_d;
  logic                      wb_prev_q, wb_prev_d;
  logic [15:0]               tiles_q, tiles_d;
  logic                      overflow_q, overflow_d;
  logic [RES_ADDR_WIDTH-1:0] res_wr_q, res_wr_d;
  logic [RES_ADDR_WIDTH-1:0] res_rd_q, res_rd_d;
  logic [CNT_W-1:0]          res_cnt_q, res_cnt_d;

  // tile buffer, one entry per fetch beat; contents are don't-care until written
  logic [A_DATA_WIDTH-1:0] a_buf   [FETCH_BEATS];
  logic [B_DATA_WIDTH-1:0] b_buf   [FETCH_BEATS];
  logic [IDX_WIDTH-1:0]    idx_buf [FETCH_BEATS];
  logic [C_DATA_WIDTH-1:0] c_buf   [FETCH_BEATS];
  logic [C_DATA_WIDTH-1:0] res_mem [RES_DEPTH];

  logic              wb_fall;
  logic              load_en;
  logic              accept;
  logic              space_ok;
  logic              issue_go;
  logic              present;
  logic              push_req;
  logic              push;
  logic              pop;
  logic              res_empty;
  logic              res_full;
  logic [BUF_AW-1:0] wr_idx;
  logic [BUF_AW-1:0] rd_idx;

  assign wr_idx = wr_cnt_q[BUF_AW-1:0];
  assign rd_idx = rd_cnt_q[BUF_AW-1:0];

  // The end of write-back is seen one cycle late (falling edge); loading may start in that cycle.
  assign wb_fall   = (state_q == RUN) && wb_prev_q && !bus.oct_write_back;
  assign load_en   = rstn && ((state_q == LOAD) || wb_fall);
  assign accept    = bus.in_valid && load_en;

  // Only issue when the whole result burst is guaranteed to fit: the octet cannot be stalled.
  assign space_ok  = (res_cnt_q <= SPACE_LIMIT);
  assign issue_go  = (state_q == ISSUE) && bus.oct_idle && space_ok;
  assign present   = (state_q == FETCH) && bus.oct_fetch && (rd_cnt_q != ALL_BEATS);

  assign res_empty = (res_cnt_q == '0);
  assign res_full  = (res_cnt_q == RES_FULL);
  assign push_req  = (state_q == RUN) && bus.oct_write_back;
  assign push      = push_req && !res_full;
  assign pop       = !res_empty && bus.out_ready;

  assign bus.in_ready       = load_en;
  assign bus.oct_start      = issue_go;
  assign bus.oct_fetch_done = fetch_done_q;
  assign bus.oct_a          = present ? a_buf[rd_idx]   : '0;
  assign bus.oct_b          = present ? b_buf[rd_idx]   : '0;
  assign bus.oct_idx        = present ? idx_buf[rd_idx] : '0;
  assign bus.oct_c          = present ? c_buf[rd_idx]   : '0;
  assign bus.out_valid      = !res_empty;
  assign bus.out_data       = res_empty ? '0 : res_mem[res_rd_q];
  assign bus.tiles_done     = tiles_q;
  assign bus.overflow       = overflow_q;

  // FSM state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LOAD;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state plus tile-side counters
  always_comb begin
    state_d      = state_q;
    wr_cnt_d     = wr_cnt_q;
    rd_cnt_d     = rd_cnt_q;
    fetch_done_d = 1'b0;
    tiles_d      = tiles_q;
    case (state_q)
      LOAD: begin
      end
      ISSUE: begin
        if (issue_go) begin
          rd_cnt_d = '0;
          state_d  = FETCH;
        end
      end
      FETCH: begin
        if (present) begin
          rd_cnt_d = rd_cnt_q + BEAT_ONE;
          if (rd_cnt_q == LAST_BEAT) begin
            fetch_done_d = 1'b1;
            state_d      = RUN;
          end
        end
      end
      RUN: begin
        if (wb_fall) begin
          tiles_d = tiles_q + 16'd1;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
    // operand capture is shared by LOAD and the write-back falling-edge cycle
    if (accept) begin
      if (wr_cnt_q == LAST_BEAT) begin
        wr_cnt_d = '0;
        state_d  = ISSUE;
      end else begin
        wr_cnt_d = wr_cnt_q + BEAT_ONE;
      end
    end
  end

  // tile counters, fetch_done pulse and tile count
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      fetch_done_q <= 1'b0;
      tiles_q      <= '0;
    end else begin
      wr_cnt_q     <= wr_cnt_d;
      rd_cnt_q     <= rd_cnt_d;
      fetch_done_q <= fetch_done_d;
      tiles_q      <= tiles_d;
    end
  end

  // tile buffer write port
  always_ff @(posedge clk) begin
    if (accept) begin
      a_buf[wr_idx]   <= bus.in_a;
      b_buf[wr_idx]   <= bus.in_b;
      idx_buf[wr_idx] <= bus.in_idx;
      c_buf[wr_idx]   <= bus.in_c;
    end
  end

  // result FIFO pointer, occupancy and overflow next-state
  always_comb begin
    res_wr_d   = res_wr_q;
    res_rd_d   = res_rd_q;
    res_cnt_d  = res_cnt_q;
    overflow_d = overflow_q || (push_req && res_full);
    wb_prev_d  = push_req;
    if (push) begin
      res_wr_d = res_wr_q + PTR_ONE;
    end
    if (pop) begin
      res_rd_d = res_rd_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   res_cnt_d = res_cnt_q + CNT_ONE;
      2'b01:   res_cnt_d = res_cnt_q - CNT_ONE;
      default: res_cnt_d = res_cnt_q;
    endcase
  end

  // result FIFO state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      res_wr_q   <= '0;
      res_rd_q   <= '0;
      res_cnt_q  <= '0;
      overflow_q <= 1'b0;
      wb_prev_q  <= 1'b0;
    end else begin
      res_wr_q   <= res_wr_d;
      res_rd_q   <= res_rd_d;
      res_cnt_q  <= res_cnt_d;
      overflow_q <= overflow_d;
      wb_prev_q  <= wb_prev_d;
    end
  end

  // result FIFO storage write port
  always_ff @(posedge clk) begin
    if (push) begin
      res_mem[res_wr_q] <= bus.oct_result;
    end
  end

endmodule

// File: tb/tb_octet_tile_feeder.sv
// tb/tb_octet_tile_feeder.sv - directed bench for octet_tile_feeder
module tb_octet_tile_feeder;

  logic clk;
  logic rstn;

  octet_tile_feeder_if #(
    .A_DATA_WIDTH(128), .B_DATA_WIDTH(128), .C_DATA_WIDTH(128), .IDX_WIDTH(32)
  ) bus ();

  octet_tile_feeder #(
    .A_DATA_WIDTH(128), .B_DATA_WIDTH(128), .C_DATA_WIDTH(128), .IDX_WIDTH(32),
    .FETCH_BEATS(8), .BEAT_CNT_WIDTH(4), .RES_DEPTH(16), .RES_ADDR_WIDTH(4)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         in_valid;
    logic [7:0]   beat;
    logic         idle;
    logic         fetch;
    logic         wb;
    logic [127:0] result;
    logic         out_ready;
    logic         e_in_ready;
    logic         e_start;
    logic         e_fdone;
    logic [127:0] e_a;
    logic [127:0] e_b;
    logic [31:0]  e_idx;
    logic [127:0] e_c;
    logic         e_out_valid;
    logic [127:0] e_out_data;
    logic [15:0]  e_tiles;
  } vec_t;

  vec_t tv [28];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_beat(input logic [7:0] v);
    bus.in_a   = {120'h0, v};
    bus.in_b   = 128'h100 + {120'h0, v};
    bus.in_idx = 32'h03020100 + {24'h0, v};
    bus.in_c   = 128'h200 + {120'h0, v};
  endtask

  task automatic load_tile(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.oct_idle = 1'b1;
      set_beat(base + 8'(i));
      #1 chk("load_in_ready", bus.in_ready, 1'b1);
    end
  endtask

  // the cycle right after the last accept: start must (or must not) be offered
  task automatic issue_cycle(input logic exp_start);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.oct_idle = 1'b1;
    #1;
    chk("issue_in_ready", bus.in_ready, 1'b0);
    chk("issue_start", bus.oct_start, exp_start);
  endtask

  task automatic fetch_tile(input logic [7:0] base);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.oct_idle  = 1'b0;
      bus.oct_fetch = 1'b1;
      #1;
      chk("fetch_a", bus.oct_a, 128'(base) + 128'(i));
      chk("fetch_b", bus.oct_b, 128'h100 + 128'(base) + 128'(i));
      chk("fetch_idx", bus.oct_idx, 32'h03020100 + 32'(base) + 32'(i));
      chk("fetch_c", bus.oct_c, 128'h200 + 128'(base) + 128'(i));
      chk("fetch_done_early", bus.oct_fetch_done, 1'b0);
    end
    @(negedge clk);
    bus.oct_fetch = 1'b0;
    #1;
    chk("fetch_done", bus.oct_fetch_done, 1'b1);
    chk("fetch_a_after", bus.oct_a, 128'h0);
  endtask

  task automatic wb_tile(input logic [7:0] rbase, input logic flow);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.oct_write_back = 1'b1;
      bus.oct_result     = 128'(rbase) + 128'(i);
      #1;
      chk("wb_fetch_done_low", bus.oct_fetch_done, 1'b0);
      if (flow && i > 0) chk("wb_flow_data", bus.out_data, 128'(rbase) + 128'(i - 1));
    end
    @(negedge clk);
    bus.oct_write_back = 1'b0;
    bus.oct_result     = '0;
    bus.oct_idle       = 1'b1;
    #1;
    chk("wb_fall_in_ready", bus.in_ready, 1'b1);
    if (flow) chk("wb_flow_last", bus.out_data, 128'(rbase) + 128'd7);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- vector table: one full tile with a flowing consumer
    for (int k = 0; k < 28; k++) begin
      tv[k] = '{in_valid: 1'b0, beat: 8'h0, idle: 1'b0, fetch: 1'b0, wb: 1'b0,
                result: '0, out_ready: 1'b0, e_in_ready: 1'b0, e_start: 1'b0,
                e_fdone: 1'b0, e_a: '0, e_b: '0, e_idx: '0, e_c: '0,
                e_out_valid: 1'b0, e_out_data: '0, e_tiles: 16'd0};
    end
    for (int k = 0; k < 8; k++) begin
      tv[k].in_valid = 1'b1; tv[k].beat = 8'(k); tv[k].idle = 1'b1; tv[k].e_in_ready = 1'b1;
    end
    tv[8].idle = 1'b1; tv[8].e_start = 1'b1;
    for (int k = 9; k < 17; k++) begin
      tv[k].fetch = 1'b1;
      tv[k].e_a   = 128'(k - 9);
      tv[k].e_b   = 128'h100 + 128'(k - 9);
      tv[k].e_idx = 32'h03020100 + 32'(k - 9);
      tv[k].e_c   = 128'h200 + 128'(k - 9);
    end
    tv[17].e_fdone = 1'b1;
    for (int k = 18; k < 26; k++) begin
      tv[k].wb = 1'b1; tv[k].result = 128'hA0 + 128'(k - 18); tv[k].out_ready = 1'b1;
    end
    for (int k = 19; k < 27; k++) begin
      tv[k].out_ready = 1'b1; tv[k].e_out_valid = 1'b1; tv[k].e_out_data = 128'hA0 + 128'(k - 19);
    end
    tv[26].idle = 1'b1; tv[26].e_in_ready = 1'b1;
    tv[27].idle = 1'b1; tv[27].e_in_ready = 1'b1; tv[27].e_tiles = 16'd1;

    // ---------------- reset state
    rstn = 1'b0;
    bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_idx = '0; bus.in_c = '0;
    bus.oct_idle = 1'b1; bus.oct_fetch = 1'b0; bus.oct_write_back = 1'b0;
    bus.oct_result = '0; bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_start", bus.oct_start, 1'b0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_tiles", bus.tiles_done, 16'd0);
    chk("rst_overflow", bus.overflow, 1'b0);
    rstn = 1'b1;
    #1 chk("rel_in_ready", bus.in_ready, 1'b1);

    for (int k = 0; k < 28; k++) begin
      @(negedge clk);
      bus.in_valid       = tv[k].in_valid;
      set_beat(tv[k].beat);
      bus.oct_idle       = tv[k].idle;
      bus.oct_fetch      = tv[k].fetch;
      bus.oct_write_back = tv[k].wb;
      bus.oct_result     = tv[k].result;
      bus.out_ready      = tv[k].out_ready;
      #1;
      chk($sformatf("v%0d_in_ready", k), bus.in_ready, tv[k].e_in_ready);
      chk($sformatf("v%0d_start", k), bus.oct_start, tv[k].e_start);
      chk($sformatf("v%0d_fdone", k), bus.oct_fetch_done, tv[k].e_fdone);
      chk($sformatf("v%0d_a", k), bus.oct_a, tv[k].e_a);
      chk($sformatf("v%0d_b", k), bus.oct_b, tv[k].e_b);
      chk($sformatf("v%0d_idx", k), bus.oct_idx, tv[k].e_idx);
      chk($sformatf("v%0d_c", k), bus.oct_c, tv[k].e_c);
      chk($sformatf("v%0d_out_valid", k), bus.out_valid, tv[k].e_out_valid);
      chk($sformatf("v%0d_out_data", k), bus.out_data, tv[k].e_out_data);
      chk($sformatf("v%0d_tiles", k), bus.tiles_done, tv[k].e_tiles);
      chk($sformatf("v%0d_overflow", k), bus.overflow, 1'b0);
    end
    bus.in_valid = 1'b0;

    // ---------------- two tiles with a stalled consumer fill the FIFO
    bus.out_ready = 1'b0;
    load_tile(8'h10); issue_cycle(1'b1); fetch_tile(8'h10); wb_tile(8'hB0, 1'b0);
    load_tile(8'h20); issue_cycle(1'b1); fetch_tile(8'h20); wb_tile(8'hC0, 1'b0);

    // third tile loads but is held back: only 0 free entries
    load_tile(8'h30);
    issue_cycle(1'b0);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      #1;
      chk("hold_start", bus.oct_start, 1'b0);
      chk("full_out_valid", bus.out_valid, 1'b1);
      chk("full_head", bus.out_data, 128'hB0);
      chk("full_tiles", bus.tiles_done, 16'd3);
      chk("full_overflow", bus.overflow, 1'b0);
    end
    // 8 pops in order; start stays withheld until the 8th pop has landed
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      chk("pop_data", bus.out_data, 128'hB0 + 128'(j));
      chk("pop_hold_start", bus.oct_start, 1'b0);
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    #1 chk("release_start", bus.oct_start, 1'b1);
    fetch_tile(8'h30);

    // ---------------- fill to 15, then push and pop in the same cycle
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.oct_write_back = 1'b1;
      bus.oct_result     = 128'hD0 + 128'(i);
      bus.out_ready      = (i == 7);
      #1;
      if (i == 7) chk("pushpop_head", bus.out_data, 128'hC0);
    end
    @(negedge clk);
    bus.oct_write_back = 1'b0;
    bus.oct_result     = '0;
    bus.out_ready      = 1'b0;
    bus.oct_idle       = 1'b1;
    #1 chk("pushpop_overflow", bus.overflow, 1'b0);
    for (int j = 0; j < 15; j++) begin
      @(negedge clk);
      bus.out_ready = 1'b1;
      #1;
      chk("drain_valid", bus.out_valid, 1'b1);
      chk("drain_data", bus.out_data, (j < 7) ? (128'hC1 + 128'(j)) : (128'hD0 + 128'(j - 7)));
    end
    @(negedge clk);
    #1;
    chk("drained_valid", bus.out_valid, 1'b0);
    chk("drained_data", bus.out_data, 128'h0);
    chk("drained_tiles", bus.tiles_done, 16'd4);
    chk("drained_overflow", bus.overflow, 1'b0);

    // ---------------- reset in the middle of a fetch
    bus.out_ready = 1'b1;
    load_tile(8'h40);
    issue_cycle(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      bus.oct_idle  = 1'b0;
      bus.oct_fetch = 1'b1;
      #1 chk("mid_fetch_a", bus.oct_a, 128'h40 + 128'(i));
    end
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    chk("mid_rst_start", bus.oct_start, 1'b0);
    chk("mid_rst_fdone", bus.oct_fetch_done, 1'b0);
    chk("mid_rst_a", bus.oct_a, 128'h0);
    chk("mid_rst_c", bus.oct_c, 128'h0);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_out_data", bus.out_data, 128'h0);
    chk("mid_rst_tiles", bus.tiles_done, 16'd0);
    chk("mid_rst_overflow", bus.overflow, 1'b0);
    bus.oct_fetch = 1'b0;
    bus.oct_idle  = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    #1 chk("post_rst_in_ready", bus.in_ready, 1'b1);

    load_tile(8'h50); issue_cycle(1'b1); fetch_tile(8'h50); wb_tile(8'hE0, 1'b1);
    @(negedge clk);
    #1;
    chk("post_rst_tiles", bus.tiles_done, 16'd1);
    chk("post_rst_empty", bus.out_valid, 1'b0);
    chk("post_rst_overflow", bus.overflow, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/octet_tile_feeder.md
Name: octet_tile_feeder

Overview:
- Upstream feeder for one sparse-tensor-core octet: buffers one full operand tile (A weight groups, 2:4 weight indices, B activations, C partial sums) from a valid/ready stream.
- Issues start, replays the tile beat-by-beat while the octet reports fetch, then pulses fetch_done.
- Captures every result beat the octet emits during write_back into a result FIFO drained by a valid/ready consumer.
- Because the octet cannot stall mid-fetch, a tile is never issued until it is fully buffered and the result FIFO has room for a whole tile.

Parameters:
- A_DATA_WIDTH, 128, width of weight-group beat.
- B_DATA_WIDTH, 128, width of activation beat.
- C_DATA_WIDTH, 128, width of partial-sum and result beat.
- IDX_WIDTH, 32, width of packed weight-index word (four 8-bit indices).
- FETCH_BEATS, 8, beats per tile fetch; also the maximum result beats per tile.
- BEAT_CNT_WIDTH, 4, counter width, must hold FETCH_BEATS.
- RES_DEPTH, 16, result FIFO entries, must be ≥ FETCH_BEATS.
- RES_ADDR_WIDTH, 4, log2(RES_DEPTH).

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat valid
- in_ready  out  1  operand beat accepted when in_valid & in_ready
- in_a  in  A_DATA_WIDTH  weight beat
- in_b  in  B_DATA_WIDTH  activation beat
- in_idx  in  IDX_WIDTH  weight-index beat
- in_c  in  C_DATA_WIDTH  partial-sum beat
- oct_idle  in  1  octet idle status
- oct_fetch  in  1  octet fetch status
- oct_write_back  in  1  octet write-back status
- oct_result  in  C_DATA_WIDTH  octet result beat, valid while oct_write_back
- oct_start  out  1  start pulse to octet
- oct_fetch_done  out  1  fetch-complete pulse to octet
- oct_a  out  A_DATA_WIDTH  weight beat to octet
- oct_b  out  B_DATA_WIDTH  activation beat to octet
- oct_idx  out  IDX_WIDTH  index beat to octet
- oct_c  out  C_DATA_WIDTH  partial-sum beat to octet
- out_valid  out  1  result FIFO non-empty
- out_ready  in  1  consumer pops when out_valid & out_ready
- out_data  out  C_DATA_WIDTH  result FIFO head
- tiles_done  out  16  count of completed tiles, wraps at 65535→0
- overflow  out  1  sticky: a result beat arrived while the FIFO was full

Behaviour:
- Reset (asynchronous, rstn low):
  - FSM returns to LOAD; tile buffer pointers, beat counters, FIFO pointers, tiles_done and overflow clear to 0.
  - All outputs read 0 except in_ready, which is 1 once rstn is high.
  - Reset mid-tile discards the buffered tile and any FIFO contents; no partial recovery.
- LOAD:
  - in_ready=1; each handshake writes one beat into the tile buffer (FETCH_BEATS entries, all four fields).
  - On the FETCH_BEATS-th accept, in_ready drops the next cycle and the FSM goes to ISSUE.
- ISSUE:
  - in_ready=0.
  - When oct_idle=1 and FIFO free entries ≥ FETCH_BEATS, oct_start=1 for exactly one cycle; the FSM moves to FETCH the following cycle.
- FETCH:
  - Every cycle oct_fetch=1, oct_a/b/idx/c present buffer entry rd_cnt combinationally and rd_cnt increments.
  - When oct_fetch=0, or once rd_cnt=FETCH_BEATS, oct_a/b/idx/c drive 0.
  - In the cycle after the last beat is presented, oct_fetch_done=1 for one cycle (registered) and the FSM moves to RUN.
- RUN:
  - Each cycle oct_write_back=1, oct_result is pushed into the FIFO.
  - When oct_write_back falls (1→0), tiles_done increments and the FSM returns to LOAD.
  - Loading the next tile may begin in that same cycle.
- Result FIFO:
  - out_data is the head entry; it drives 0 when the FIFO is empty.
  - A push and a pop in the same cycle are both honoured and the count is unchanged.
  - A push while full is dropped and sets overflow; this cannot occur with correct octet behaviour.
  - Pointers wrap at RES_DEPTH.
- Status inputs:
  - oct_write_back or oct_fetch asserted outside its expected state is ignored; no push or pop occurs.
- Latency:
  - From the last input accept to oct_start is 1 cycle minimum, more if the octet is not idle or the FIFO is short of space.

Test Plan:
- Reset, then stream 8 beats with in_a=i, in_b=0x100+i, in_idx=0x03020100+i, in_c=0x200+i, octet model idle → in_ready=0 after beat 8; oct_start pulses once, 1 cycle after the final accept.
- Octet model holds oct_fetch 8 cycles → oct_a sequence 0..7 and oct_c sequence 0x200..0x207; oct_fetch_done high exactly 1 cycle after beat 7; oct_a=0 afterward.
- Octet model drives write_back 8 cycles with results 0xA0..0xA7, out_ready=1 → out_data 0xA0..0xA7 in order; tiles_done=1; in_ready returns to 1.
- out_ready=0 across two tiles (16 results) → out_valid=1, FIFO full; a third tile loads but oct_start is withheld until 8 pops are made.
- Pop and push in the same cycle with the FIFO at 15 entries → count stays 15, order preserved, overflow=0.
- Assert rstn=0 mid-FETCH after 3 beats → all outputs 0, tiles_done=0; after release, a new tile completes normally.
